dma64_responder: RTL and testbench

- Target-side DMA engine for the 64-bit accelerator DMA interface.
- Accepts read and write control requests from an accelerator, then streams 64-bit beats between its chnl handshakes and a single-port beat-addressed memory.
- Stands in for the system DMA plus DRAM in block-level simulation and on the FPGA test harness.

---
 rtl/dma64_pkg.sv | 26 ++
 rtl/dma_skid_fifo.sv | 71 +++++++
 rtl/dma64_responder.sv | 173 +++++++++++++++++
 tb/tb_dma64_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma64_pkg
// Description : Shared constants and state encoding for the 64-bit DMA
//               responder and its read-path FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package dma64_pkg;

  localparam int         DMA_DATA_W    = 64;
  localparam logic [2:0] DMA_SIZE_WORD = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RD   = ST_RD,
    S_WR   = ST_WR,
    S_DONE = ST_DONE
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dma_skid_fifo
// Description : Two-entry show-ahead FIFO. The head is presented whenever the
//               FIFO is non-empty; push and pop in the same cycle on a full
//               FIFO is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_skid_fifo
  import dma64_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count,
  output logic              o_empty,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_empty   = (r_count == 2'd0);
  assign o_full    = (r_count == 2'd2);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  // Drive zero when empty so stale entries never leak onto the channel.
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage: no reset needed, the occupancy count guards every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma64_responder.sv
`default_nettype none
// ============================================================================
// Module      : dma64_responder
// Description : Target-side 64-bit DMA engine. Accepts read/write control
//               requests and streams beats between the chnl handshakes and a
//               single-port beat-addressed memory with one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dma64_responder
  import dma64_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_read_ctrl_valid,
  output logic                  dma_read_ctrl_ready,
  input  logic [31:0]           dma_read_ctrl_data_index,
  input  logic [LEN_W-1:0]      dma_read_ctrl_data_length,
  input  logic [2:0]            dma_read_ctrl_data_size,
  output logic                  dma_read_chnl_valid,
  input  logic                  dma_read_chnl_ready,
  output logic [DMA_DATA_W-1:0] dma_read_chnl_data,
  input  logic                  dma_write_ctrl_valid,
  output logic                  dma_write_ctrl_ready,
  input  logic [31:0]           dma_write_ctrl_data_index,
  input  logic [LEN_W-1:0]      dma_write_ctrl_data_length,
  input  logic [2:0]            dma_write_ctrl_data_size,
  input  logic                  dma_write_chnl_valid,
  output logic                  dma_write_chnl_ready,
  input  logic [DMA_DATA_W-1:0] dma_write_chnl_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DMA_DATA_W-1:0] mem_wdata,
  input  logic [DMA_DATA_W-1:0] mem_rdata,
  output logic                  busy,
  output logic                  xfer_done,
  output logic                  size_err
);

  dma_state_e            r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [LEN_W-1:0]      r_remaining;
  logic                  r_inflight;
  logic                  r_size_err;

  logic                  w_in_idle;
  logic                  w_in_rd;
  logic                  w_in_wr;
  logic                  w_rd_accept;
  logic                  w_wr_accept;
  logic                  w_rd_pop;
  logic [2:0]            w_rd_occ;
  logic                  w_rd_issue;
  logic                  w_wr_ready;
  logic                  w_wr_fire;
  logic [DMA_DATA_W-1:0] w_fifo_head;
  logic [1:0]            w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_unused;

  assign w_in_idle   = (r_state == S_IDLE);
  assign w_in_rd     = (r_state == S_RD);
  assign w_in_wr     = (r_state == S_WR);

  // Read request wins when both directions ask in the same cycle.
  assign w_rd_accept = w_in_idle && dma_read_ctrl_valid;
  assign w_wr_accept = w_in_idle && dma_write_ctrl_valid && !dma_read_ctrl_valid;

  assign w_rd_pop    = w_in_rd && !w_fifo_empty && dma_read_chnl_ready;

  // Slots already claimed (queued + returning), less the beat leaving now.
  // Counting the departing beat keeps one read per cycle in steady state.
  assign w_rd_occ    = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_rd_pop};
  assign w_rd_issue  = w_in_rd && (r_remaining != '0) && (w_rd_occ < 3'd2);

  assign w_wr_ready  = w_in_wr && (r_remaining != '0);
  assign w_wr_fire   = w_wr_ready && dma_write_chnl_valid;

  dma_skid_fifo #(
    .DATA_W      (DMA_DATA_W)
  ) u_rd_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (mem_rdata),
    .i_pop       (w_rd_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  // Input-dependent outputs are forced low while reset is held.
  assign dma_read_ctrl_ready  = !rst && w_rd_accept;
  assign dma_write_ctrl_ready = !rst && w_wr_accept;
  assign dma_read_chnl_valid  = !rst && w_in_rd && !w_fifo_empty;
  assign dma_read_chnl_data   = w_fifo_head;
  assign dma_write_chnl_ready = !rst && w_wr_ready;
  assign mem_en               = !rst && (w_rd_issue || w_wr_fire);
  assign mem_we               = !rst && w_wr_fire;
  assign mem_addr             = r_addr;
  assign mem_wdata            = (!rst && w_wr_fire) ? dma_write_chnl_data : '0;
  assign busy                 = w_in_rd || w_in_wr;
  assign xfer_done            = (r_state == S_DONE);
  assign size_err             = r_size_err;

  // Index bits above the memory width are intentionally dropped (address wraps).
  assign w_unused = ^{dma_read_ctrl_data_index[31:ADDR_W],
                      dma_write_ctrl_data_index[31:ADDR_W], w_fifo_full};

  // Transfer sequencer: request capture, beat counting and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_size_err  <= 1'b0;
    end else begin
      r_inflight <= w_rd_issue;
      case (r_state)
        S_IDLE: begin
          if (w_rd_accept) begin
            r_addr      <= dma_read_ctrl_data_index[ADDR_W-1:0];
            r_remaining <= dma_read_ctrl_data_length;
            if (dma_read_ctrl_data_size != DMA_SIZE_WORD) begin
              r_size_err <= 1'b1;
            end
            r_state <= (dma_read_ctrl_data_length == '0) ? S_DONE : S_RD;
          end else if (w_wr_accept) begin
            r_addr      <= dma_write_ctrl_data_index[ADDR_W-1:0];
            r_remaining <= dma_write_ctrl_data_length;
            if (dma_write_ctrl_data_size != DMA_SIZE_WORD) begin
              r_size_err <= 1'b1;
            end
            r_state <= (dma_write_ctrl_data_length == '0) ? S_DONE : S_WR;
          end
        end
        S_RD: begin
          if (w_rd_issue) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
          end
          // Finish only once every issued beat has been handed over.
          if ((r_remaining == '0) && !r_inflight && w_fifo_empty) begin
            r_state <= S_DONE;
          end
        end
        S_WR: begin
          if (w_wr_fire) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma64_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma64_responder
// Description : Self-checking bench for dma64_responder with a behavioural
//               memory and expected-value model derived from transfer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma64_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_ctrl_valid, rd_ctrl_ready;
  logic [31:0] rd_idx, rd_len;
  logic [2:0]  rd_size;
  logic        rd_chnl_valid, rd_chnl_ready;
  logic [63:0] rd_chnl_data;
  logic        wr_ctrl_valid, wr_ctrl_ready;
  logic [31:0] wr_idx, wr_len;
  logic [2:0]  wr_size;
  logic        wr_chnl_valid, wr_chnl_ready;
  logic [63:0] wr_chnl_data;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        busy, xfer_done, size_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma64_responder #(.ADDR_W(16), .LEN_W(32)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .dma_read_ctrl_valid        (rd_ctrl_valid),
    .dma_read_ctrl_ready        (rd_ctrl_ready),
    .dma_read_ctrl_data_index   (rd_idx),
    .dma_read_ctrl_data_length  (rd_len),
    .dma_read_ctrl_data_size    (rd_size),
    .dma_read_chnl_valid        (rd_chnl_valid),
    .dma_read_chnl_ready        (rd_chnl_ready),
    .dma_read_chnl_data         (rd_chnl_data),
    .dma_write_ctrl_valid       (wr_ctrl_valid),
    .dma_write_ctrl_ready       (wr_ctrl_ready),
    .dma_write_ctrl_data_index  (wr_idx),
    .dma_write_ctrl_data_length (wr_len),
    .dma_write_ctrl_data_size   (wr_size),
    .dma_write_chnl_valid       (wr_chnl_valid),
    .dma_write_chnl_ready       (wr_chnl_ready),
    .dma_write_chnl_data        (wr_chnl_data),
    .mem_en                     (mem_en),
    .mem_we                     (mem_we),
    .mem_addr                   (mem_addr),
    .mem_wdata                  (mem_wdata),
    .mem_rdata                  (mem_rdata),
    .busy                       (busy),
    .xfer_done                  (xfer_done),
    .size_err                   (size_err)
  );

  // Unwritten locations hold a per-address pattern (the "preload").
  function automatic logic [63:0] pat(input logic [15:0] a);
    return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
  endfunction

  logic [63:0] mem [0:65535];
  bit          written [0:65535];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= written[mem_addr] ? mem[mem_addr] : pat(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string ph);
    chk({ph, "_rd_ctrl_ready"}, rd_ctrl_ready, 0);
    chk({ph, "_wr_ctrl_ready"}, wr_ctrl_ready, 0);
    chk({ph, "_rd_chnl_valid"}, rd_chnl_valid, 0);
    chk({ph, "_rd_chnl_data"},  rd_chnl_data, 0);
    chk({ph, "_wr_chnl_ready"}, wr_chnl_ready, 0);
    chk({ph, "_mem_en"},        mem_en, 0);
    chk({ph, "_mem_we"},        mem_we, 0);
    chk({ph, "_mem_addr"},      mem_addr, 0);
    chk({ph, "_mem_wdata"},     mem_wdata, 0);
    chk({ph, "_busy"},          busy, 0);
    chk({ph, "_xfer_done"},     xfer_done, 0);
    chk({ph, "_size_err"},      size_err, 0);
  endtask

  // mode 0: consumer always ready; mode 1: random ready with 5-cycle stalls.
  // hold_wr: a write request (fields preset) is raised together with the read.
  task automatic do_read(input logic [31:0] idx, input int len, input int mode,
                         input logic [2:0] size, input bit hold_wr);
    int          got, issued, step, first_valid, done_cnt, done_step, budget, stall_left, r;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [15:0] a0;
    a0 = idx[15:0];
    @(negedge clk);
    rd_ctrl_valid = 1'b1; rd_idx = idx; rd_len = len; rd_size = size;
    wr_chnl_valid = 1'b1;
    if (hold_wr) wr_ctrl_valid = 1'b1;
    #1;
    chk("rd_ctrl_ready", rd_ctrl_ready, 1);
    if (hold_wr) chk("wr_ctrl_ready_prio", wr_ctrl_ready, 0);
    got = 0; issued = 0; step = 0; first_valid = -1; done_cnt = 0; done_step = -1;
    stall_left = 0; prev_stall = 1'b0; prev_data = '0;
    budget = len * 8 + 40;
    while (done_cnt == 0 && step < budget) begin
      @(negedge clk);
      rd_ctrl_valid = 1'b0;
      step++;
      if (mode == 0) rd_chnl_ready = 1'b1;
      else if (stall_left > 0) begin
        rd_chnl_ready = 1'b0; stall_left--;
      end else begin
        r = int'($urandom_range(0, 9));
        if (r == 0) begin stall_left = 4; rd_chnl_ready = 1'b0; end
        else rd_chnl_ready = (r > 3);
      end
      #1;
      if (hold_wr) chk("wr_ctrl_ready_busy", wr_ctrl_ready, 0);
      chk("wr_chnl_ready_in_rd", wr_chnl_ready, 0);
      if (prev_stall) begin
        chk("rd_valid_hold", rd_chnl_valid, 1);
        chk("rd_data_hold", rd_chnl_data, prev_data);
      end
      if (mem_en) begin
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 16'(a0 + 16'(issued)));
        issued++;
      end
      if (rd_chnl_valid && first_valid < 0) first_valid = step;
      if (rd_chnl_valid && rd_chnl_ready) begin
        chk("rd_data", rd_chnl_data, pat(16'(a0 + 16'(got))));
        if (mode == 0) chk("rd_rate", step, first_valid + got);
        got++;
      end
      chk("rd_outstanding", (issued - got) <= 2, 1);
      prev_stall = rd_chnl_valid && !rd_chnl_ready;
      prev_data  = rd_chnl_data;
      if (xfer_done) begin done_cnt++; done_step = step; end
      else chk("rd_busy", busy, 1);
    end
    chk("rd_done_pulse", done_cnt, 1);
    chk("rd_beats", got, len);
    chk("rd_issued", issued, len);
    if (mode == 0 && len > 0) chk("rd_latency", first_valid, 3);
    if (len == 0) chk("rd_len0_done_step", done_step, 1);
    @(negedge clk);
    #1;
    chk("rd_done_once", xfer_done, 0);
    chk("rd_idle", busy, 0);
    if (hold_wr) chk("wr_ctrl_ready_after_rd", wr_ctrl_ready, 1);
  endtask

  // pre: the write request is already valid and being accepted this cycle.
  task automatic do_write(input logic [31:0] idx, input int len,
                          input logic [2:0] size, input bit pre);
    logic [63:0] sent_q [$];
    int          sent, step, done_step, last_step, budget;
    logic [15:0] a0;
    logic [63:0] d;
    a0 = idx[15:0];
    if (!pre) begin
      @(negedge clk);
      wr_ctrl_valid = 1'b1; wr_idx = idx; wr_len = len; wr_size = size;
      #1;
    end
    chk("wr_ctrl_ready", wr_ctrl_ready, 1);
    sent = 0; step = 0; done_step = -1; last_step = -1;
    budget = len * 6 + 40;
    while (done_step < 0 && step < budget) begin
      @(negedge clk);
      wr_ctrl_valid = 1'b0;
      step++;
      wr_chnl_valid = ($urandom_range(0, 3) != 0);
      d = {$urandom, $urandom};
      wr_chnl_data = d;
      #1;
      chk("wr_chnl_ready", wr_chnl_ready, sent < len);
      if (wr_chnl_valid && sent < len) begin
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 16'(a0 + 16'(sent)));
        chk("wr_mem_wdata", mem_wdata, d);
        sent_q.push_back(d);
        sent++;
        if (sent == len) last_step = step;
      end else begin
        chk("wr_no_mem", mem_en, 0);
      end
      if (xfer_done) done_step = step;
    end
    chk("wr_beats", sent, len);
    if (len > 0) chk("wr_done_step", done_step, last_step + 1);
    else chk("wr_len0_done_step", done_step, 1);
    @(negedge clk);
    wr_chnl_valid = 1'b0;
    #1;
    chk("wr_done_once", xfer_done, 0);
    foreach (sent_q[k]) chk("wr_mem_content", mem[16'(a0 + 16'(k))], sent_q[k]);
  endtask

  initial begin
    rst = 1'b1;
    rd_ctrl_valid = 0; rd_idx = 0; rd_len = 0; rd_size = 3'b010; rd_chnl_ready = 0;
    wr_ctrl_valid = 0; wr_idx = 0; wr_len = 0; wr_size = 3'b010;
    wr_chnl_valid = 0; wr_chnl_data = 0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Long in-order stream at full rate.
    do_read(32'd0, 7880, 0, 3'b010, 1'b0);
    // Back-pressured stream.
    do_read(32'd10000, 128, 1, 3'b010, 1'b0);
    // Write with gaps.
    do_write(32'd10128, 249, 3'b010, 1'b0);
    // Simultaneous requests: read first, then the held write.
    wr_idx = 32'd30000; wr_len = 32'd5; wr_size = 3'b010;
    do_read(32'd20000, 6, 1, 3'b010, 1'b1);
    do_write(32'd30000, 5, 3'b010, 1'b1);
    // Zero-length transfers.
    do_read(32'd40000, 0, 0, 3'b010, 1'b0);
    do_write(32'd40000, 0, 3'b010, 1'b0);
    chk("size_err_clear", size_err, 0);
    // Unsupported size still transfers.
    do_write(32'd41000, 3, 3'b011, 1'b0);
    chk("size_err_set", size_err, 1);
    // Address wrap.
    do_read(32'd65534, 4, 0, 3'b010, 1'b0);
    chk("size_err_sticky", size_err, 1);

    // Reset in the middle of a read stream.
    @(negedge clk);
    rd_ctrl_valid = 1'b1; rd_idx = 32'd50000; rd_len = 32'd100; rd_size = 3'b010;
    @(negedge clk);
    rd_ctrl_valid = 1'b0; rd_chnl_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; wr_chnl_valid = 1'b1;
    @(negedge clk);
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("post_rst_no_done", xfer_done, 0);
      chk("post_rst_no_mem", mem_en, 0);
      chk("post_rst_no_valid", rd_chnl_valid, 0);
      @(negedge clk);
    end
    wr_chnl_valid = 1'b0;
    do_read(32'd123, 3, 1, 3'b010, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
